// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared SCCB state encoding and protocol constants
package sccb_pkg;
  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, SUB, SUB_ACK, WDAT, WDAT_ACK, RDAT, RDAT_NA, WAIT_STOP
  } sccb_state_t;

  localparam logic SCCB_RD   = 1'b1;
  localparam logic SCCB_WR   = 1'b0;
  localparam int   BYTE_BITS = 8;
endpackage

// File: rtl/sccb_line_sync.sv
// rtl/sccb_line_sync.sv - SIO_C/SIO_D synchroniser with edge and START/STOP pulse detection
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic c_line,
  input  logic d_line,
  output logic data,
  output logic rise,
  output logic fall,
  output logic start,
  output logic stop
);
  logic [SYNC_STAGES-1:0] c_sync;
  logic [SYNC_STAGES-1:0] d_sync;
  logic c_q, d_q, c_s, d_s;

  // Reset to the idle-bus level so leaving reset does not fake a bus event.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_sync <= '1;
      d_sync <= '1;
      c_q    <= 1'b1;
      d_q    <= 1'b1;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], c_line};
      d_sync <= {d_sync[SYNC_STAGES-2:0], d_line};
      c_q    <= c_s;
      d_q    <= d_s;
    end
  end

  assign c_s   = c_sync[SYNC_STAGES-1];
  assign d_s   = d_sync[SYNC_STAGES-1];
  assign data  = d_s;
  assign rise  = c_s & ~c_q;
  assign fall  = ~c_s & c_q;
  assign start = c_s & d_q & ~d_s;
  assign stop  = c_s & ~d_q & d_s;
endmodule

// File: rtl/sccb_slave.sv
// rtl/sccb_slave.sv - SCCB responder decoding ID/sub-address/data onto a register-file port
module sccb_slave
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEVICE_ID   = 7'h21,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       SIO_C,
  input  logic       SIO_D_IN,
  output logic       SIO_D_OE,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       abort
);
  sccb_state_t state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [7:0]  shift, shift_n, tx, tx_n, sub_addr, sub_n, wdata_n, byte_in;
  logic        pend, pend_n, rw, rw_n, re_q, oe_n, we_n, re_n, busy_n, abort_n, in_ack;
  logic        data, rise, fall, start, stop;

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(PCLK), .rst(PRESET), .c_line(SIO_C), .d_line(SIO_D_IN),
    .data(data), .rise(rise), .fall(fall), .start(start), .stop(stop)
  );

  assign reg_addr = sub_addr;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;   cnt <= '0;      pend <= 1'b0;     shift <= '0;
      tx <= '0;        sub_addr <= '0; rw <= 1'b0;       re_q <= 1'b0;
      SIO_D_OE <= 1'b0; reg_wdata <= '0; reg_we <= 1'b0; reg_re <= 1'b0;
      busy <= 1'b0;    abort <= 1'b0;
    end else begin
      state <= state_n; cnt <= cnt_n;     pend <= pend_n;   shift <= shift_n;
      tx <= tx_n;       sub_addr <= sub_n; rw <= rw_n;      re_q <= reg_re;
      SIO_D_OE <= oe_n; reg_wdata <= wdata_n; reg_we <= we_n; reg_re <= re_n;
      busy <= busy_n;   abort <= abort_n;
    end
  end

  always_comb begin
    state_n = state;  cnt_n = cnt;     pend_n = pend;      shift_n = shift;
    tx_n = tx;        sub_n = sub_addr; rw_n = rw;         oe_n = SIO_D_OE;
    wdata_n = reg_wdata; we_n = 1'b0;  re_n = 1'b0;        busy_n = busy;
    abort_n = 1'b0;
    byte_in = {shift[6:0], data};
    in_ack  = state inside {ID_ACK, SUB_ACK, WDAT_ACK, RDAT_NA};
    if (re_q) tx_n = reg_rdata;
    if (start || stop) begin
      // The SIO_C rise that precedes a START/STOP is not a data bit (pend).
      abort_n = in_ack || (cnt > {3'b000, pend});
      state_n = start ? ID : IDLE;
      busy_n  = start;
      oe_n    = 1'b0;
      cnt_n   = '0;
      pend_n  = 1'b0;
    end else if (rise) begin
      unique case (state)
        ID, SUB, WDAT: begin
          shift_n = byte_in;
          cnt_n   = cnt + 4'd1;
          pend_n  = 1'b1;
          if (cnt == 4'(BYTE_BITS - 1)) begin
            if (state == ID && byte_in[7:1] == DEVICE_ID && byte_in[0] == SCCB_RD) re_n = 1'b1;
            if (state == SUB) sub_n = byte_in;
            if (state == WDAT) begin
              we_n    = 1'b1;
              wdata_n = byte_in;
            end
          end
        end
        RDAT: begin
          cnt_n  = cnt + 4'd1;
          pend_n = 1'b1;
        end
        RDAT_NA: begin
          if (data) state_n = WAIT_STOP;
          else begin
            re_n    = 1'b1;
            state_n = RDAT;
          end
        end
        default: ;
      endcase
    end else if (fall) begin
      pend_n = 1'b0;
      unique case (state)
        ID, SUB, WDAT: begin
          if (cnt == 4'(BYTE_BITS)) begin
            cnt_n = '0;
            if (state == ID && shift[7:1] != DEVICE_ID) state_n = WAIT_STOP;
            else begin
              oe_n    = 1'b1;
              rw_n    = (state == ID) ? shift[0] : rw;
              state_n = (state == ID) ? ID_ACK : (state == SUB) ? SUB_ACK : WDAT_ACK;
            end
          end
        end
        ID_ACK: begin
          if (rw == SCCB_WR) begin
            oe_n    = 1'b0;
            state_n = SUB;
          end else begin
            oe_n    = ~tx[7];
            tx_n    = {tx[6:0], 1'b0};
            state_n = RDAT;
          end
        end
        SUB_ACK: begin
          oe_n    = 1'b0;
          state_n = WDAT;
        end
        WDAT_ACK: begin
          oe_n    = 1'b0;
          state_n = WAIT_STOP;
        end
        RDAT: begin
          if (cnt == 4'(BYTE_BITS)) begin
            oe_n    = 1'b0;
            cnt_n   = '0;
            state_n = RDAT_NA;
          end else begin
            oe_n = ~tx[7];
            tx_n = {tx[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sccb_slave.sv
// tb/tb_sccb_slave.sv - self-checking bench for sccb_slave driving a bit-level SCCB master
module tb_sccb_slave;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       oe, we, re, busy, abort;
  logic [7:0] addr, wdata, rdata;
  logic       sda_pin;
  logic       mem_init = 1'b1;
  logic [7:0] regfile [256];
  logic [7:0] ref_mem [256];

  int total = 0, bad = 0;
  int we_cnt = 0, re_cnt = 0, abort_cnt = 0, oe_cnt = 0, both_cnt = 0;
  logic [7:0] we_addr = 8'h00, we_data = 8'h00, re_addr = 8'h00;
  int   oe_lat;
  logic na_pin;

  assign sda_pin = sda_m & ~oe;
  always #5 clk = ~clk;

  sccb_slave #(.DEVICE_ID(7'h21), .SYNC_STAGES(2)) dut (
    .PCLK(clk), .PRESET(rst), .SIO_C(scl), .SIO_D_IN(sda_pin), .SIO_D_OE(oe),
    .reg_addr(addr), .reg_wdata(wdata), .reg_we(we), .reg_re(re),
    .reg_rdata(rdata), .busy(busy), .abort(abort)
  );

  // Register file attached to the port: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) regfile[i] <= 8'h00;
      regfile[8'h0A] <= 8'h76;
      rdata <= 8'h00;
    end else begin
      if (we) regfile[addr] <= wdata;
      rdata <= re ? regfile[addr] : 8'h00;
    end
  end

  always @(negedge clk) begin
    if (we) begin we_cnt++; we_addr = addr; we_data = wdata; end
    if (re) begin re_cnt++; re_addr = addr; end
    if (abort) abort_cnt++;
    if (oe) oe_cnt++;
    if (we && re) both_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic s);
    oe_lat = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (oe && oe_lat == 0) oe_lat = i;
    end
    sda_m = b; tick(4); scl = 1'b1; tick(4); s = sda_pin; tick(4); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic recv_byte(input logic na, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin send_bit(1'b1, s); d[i] = s; end
    send_bit(na, s);
    na_pin = s;
  endtask

  task automatic start_cond();
    tick(2); sda_m = 1'b1; tick(4); scl = 1'b1; tick(4); sda_m = 1'b0; tick(4); scl = 1'b0;
  endtask

  task automatic stop_cond();
    tick(2); sda_m = 1'b0; tick(4); scl = 1'b1; tick(4); sda_m = 1'b1; tick(8);
  endtask

  task automatic run_txn(input int kind, input logic [7:0] id, sub, dat,
                         output logic [2:0] acks, output logic [7:0] rd, output logic bmid);
    rd = 8'h00;
    start_cond();
    bmid = busy;
    send_byte((kind == 0) ? id : 8'h42, acks[2]);
    send_byte(sub, acks[1]);
    if (kind == 0) send_byte(dat, acks[0]);
    else begin
      stop_cond();
      start_cond();
      send_byte(8'h43, acks[0]);
      recv_byte(1'b1, rd);
    end
    stop_cond();
  endtask

  // Transaction-level reference: a valid write stores, a read returns stored data.
  task automatic model(input int kind, input logic [7:0] id, sub, dat,
                       output logic [2:0] acks, output int ewe, output logic [7:0] erd);
    acks = 3'b111; ewe = 0; erd = 8'h00;
    if (kind == 0) begin
      if (id == {7'h21, 1'b0}) begin ewe = 1; ref_mem[sub] = dat; end
      else acks = 3'b000;
    end else erd = ref_mem[sub];
  endtask

  task automatic do_check(input string tag, input int kind, input logic [7:0] id, sub, dat,
                          input logic [2:0] eacks, input int ewe, input logic [7:0] erd);
    int we0, re0, ab0, oe0;
    logic [2:0] acks;
    logic [7:0] rd;
    logic bmid;
    we0 = we_cnt; re0 = re_cnt; ab0 = abort_cnt; oe0 = oe_cnt;
    run_txn(kind, id, sub, dat, acks, rd, bmid);
    chk({tag, " acks"}, acks, eacks);
    chk({tag, " busy_mid"}, bmid, 1);
    chk({tag, " busy_end"}, busy, 0);
    chk({tag, " oe_end"}, oe, 0);
    chk({tag, " we_count"}, we_cnt - we0, ewe);
    chk({tag, " abort_count"}, abort_cnt - ab0, 0);
    chk({tag, " re_count"}, re_cnt - re0, (kind == 1) ? 1 : 0);
    if (ewe != 0) begin
      chk({tag, " we_addr"}, we_addr, sub);
      chk({tag, " we_data"}, we_data, dat);
    end
    if (kind == 1) begin
      chk({tag, " rd_data"}, rd, erd);
      chk({tag, " re_addr"}, re_addr, sub);
      chk({tag, " na_released"}, na_pin, 1);
    end
    if (eacks == 3'b000) chk({tag, " oe_quiet"}, oe_cnt - oe0, 0);
  endtask

  typedef struct {
    int         kind;
    logic [7:0] id, sub, dat;
    logic [2:0] acks;
    int         we;
    logic [7:0] rd;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    logic [2:0] macks;
    int mwe, ab0, we0, re0;
    logic [7:0] mrd, d1, d2, id, sub, dat;
    logic acked, s;
    int kind;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_mem[8'h0A] = 8'h76;
    tbl[0] = '{0, 8'h42, 8'h12, 8'h80, 3'b111, 1, 8'h00};
    tbl[1] = '{1, 8'h42, 8'h0A, 8'h00, 3'b111, 0, 8'h76};
    tbl[2] = '{0, 8'h60, 8'h12, 8'h34, 3'b000, 0, 8'h00};
    tbl[3] = '{1, 8'h42, 8'h12, 8'h00, 3'b111, 0, 8'h80};
    tbl[4] = '{0, 8'h42, 8'hFF, 8'hA5, 3'b111, 1, 8'h00};
    tbl[5] = '{1, 8'h42, 8'hFF, 8'h00, 3'b111, 0, 8'hA5};

    tick(5);
    chk("reset oe", oe, 0);
    chk("reset busy", busy, 0);
    chk("reset strobes", {we, re, abort}, 0);
    chk("reset addr", addr, 0);
    chk("reset wdata", wdata, 0);
    rst = 1'b0; mem_init = 1'b0;
    tick(5);

    foreach (tbl[i]) begin
      model(tbl[i].kind, tbl[i].id, tbl[i].sub, tbl[i].dat, macks, mwe, mrd);
      do_check($sformatf("vec%0d", i), tbl[i].kind, tbl[i].id, tbl[i].sub, tbl[i].dat,
               tbl[i].acks, tbl[i].we, tbl[i].rd);
    end

    // STOP four bits into the sub-address, then a clean write.
    ab0 = abort_cnt;
    start_cond();
    send_byte(8'h42, acked);
    chk("ack latency", oe_lat, 3);
    for (int i = 0; i < 4; i++) send_bit(i[0], s);
    stop_cond();
    chk("midbyte abort", abort_cnt - ab0, 1);
    chk("midbyte oe", oe, 0);
    chk("midbyte busy", busy, 0);
    model(0, 8'h42, 8'h33, 8'hC4, macks, mwe, mrd);
    do_check("after_abort", 0, 8'h42, 8'h33, 8'hC4, macks, mwe, mrd);

    // Repeated START after the ID ack of a write turns into a read.
    we0 = we_cnt; re0 = re_cnt;
    start_cond(); send_byte(8'h42, acked);
    start_cond(); send_byte(8'h43, acked);
    chk("rstart ack", acked, 1);
    recv_byte(1'b1, d1);
    stop_cond();
    chk("rstart rd", d1, ref_mem[8'h33]);
    chk("rstart no we", we_cnt - we0, 0);
    chk("rstart re", re_cnt - re0, 1);

    // Master ack (NA=0) requests the same register again.
    re0 = re_cnt;
    start_cond(); send_byte(8'h43, acked);
    recv_byte(1'b0, d1);
    recv_byte(1'b1, d2);
    stop_cond();
    chk("repeat rd1", d1, ref_mem[8'h33]);
    chk("repeat rd2", d2, ref_mem[8'h33]);
    chk("repeat re", re_cnt - re0, 2);

    // Reset while the slave holds the sub-address ack low.
    start_cond(); send_byte(8'h42, acked);
    for (int i = 7; i >= 0; i--) send_bit(i[0], s);
    tick(4);
    chk("pre-reset oe", oe, 1);
    rst = 1'b1;
    tick(1);
    chk("reset mid oe", oe, 0);
    chk("reset mid addr", addr, 0);
    chk("reset mid busy", busy, 0);
    rst = 1'b0;
    stop_cond();
    model(0, 8'h42, 8'h77, 8'h99, macks, mwe, mrd);
    do_check("after_reset", 0, 8'h42, 8'h77, 8'h99, macks, mwe, mrd);

    for (int n = 0; n < 14; n++) begin
      kind = int'($urandom_range(0, 1));
      sub = 8'($urandom_range(0, 255));
      dat = 8'($urandom_range(0, 255));
      id = 8'h42;
      if (kind == 0 && $urandom_range(0, 3) == 0)
        do id = 8'($urandom_range(0, 255)); while (id[7:1] == 7'h21);
      model(kind, id, sub, dat, macks, mwe, mrd);
      do_check($sformatf("rand%0d", n), kind, id, sub, dat, macks, mwe, mrd);
    end

    chk("we_re_overlap", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
